cdc_sync_bank: RTL and testbench

Parametrised multi-channel bit synchronizer for the destination clock domain. It takes WIDTH independent, asynchronous single-bit signals through a STAGES-deep flop chain. It can optionally pass them through a per-channel stability filter. It produces the synchronized level, one-cycle rise/fall pulses and a warm-up ready flag. It sits at the boundary where quasi-static control bits (enables, status flags, interrupts) enter a clock domain. It is not for multi-bit buses that need coherency; use a handshake or FIFO crossing for those.

---
 rtl/cdc_sync_bank.sv | 161 ++++++++++++++++
 tb/tb_cdc_sync_bank.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cdc_sync_bank.sv
// Purpose : bank of WIDTH independent single-bit synchronizers into clk_dst, with optional
//           per-channel stability filter, one-cycle rise/fall pulses and a warm-up ready flag.
// Latency : STAGES edges data_in -> data_out (STAGES+FILT_CYCLES with the filter compiled in).
// Backpressure: none; level signals only, every channel sampled every clk_dst edge.
//
// Ports:
//   clk_dst    - destination clock, the only clock in the block
//   rst_n      - synchronous active-low reset
//   data_in    - WIDTH asynchronous quasi-static bits
//   data_out   - synchronized (optionally filtered) level
//   rise_pulse - one-cycle pulse on the first cycle data_out shows 0->1
//   fall_pulse - one-cycle pulse on the first cycle data_out shows 1->0
//   sync_ready - high once the pipeline has flushed after reset
//
// Build option: define CDC_SYNC_BANK_FILTER_EN to compile in the per-channel stability
// counters (data_out only follows after FILT_CYCLES consecutive cycles of a new value).
// Not for multi-bit coherent buses.

module cdc_sync_bank #(
    parameter int               WIDTH       = 8,
    parameter int               STAGES      = 3,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    parameter int               FILT_CYCLES = 4
) (
    input  logic             clk_dst,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             sync_ready
);

    // Elaboration-time parameter checks.
    if (STAGES < 2) begin : g_bad_stages
        $error("cdc_sync_bank: STAGES must be >= 2");
    end
    if (FILT_CYCLES < 1 || FILT_CYCLES > 256) begin : g_bad_filt
        $error("cdc_sync_bank: FILT_CYCLES must be in 1..256");
    end

`ifdef CDC_SYNC_BANK_FILTER_EN
    localparam int READY_CYC = STAGES + FILT_CYCLES;
`else
    localparam int READY_CYC = STAGES;
`endif
    localparam int RW = $clog2(READY_CYC + 1);

    // ------------------------------------------------------------------
    // Synchronizer chain. Stage 0 is the metastability-catching flop.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sync [STAGES];

    always_ff @(posedge clk_dst) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                sync[k] <= RESET_VAL;
            end
        end else begin
            sync[0] <= data_in;
            for (int k = 1; k < STAGES; k++) begin
                sync[k] <= sync[k-1];
            end
        end
    end

    // data_out_nxt is the value data_out takes on the coming edge; the edge
    // detector needs it during warm-up (see data_out_d below).
    logic [WIDTH-1:0] data_out_nxt;

`ifdef CDC_SYNC_BANK_FILTER_EN
    // ------------------------------------------------------------------
    // Stability filter: a channel flips only after sync_q has disagreed
    // with data_out for FILT_CYCLES consecutive cycles. Any agreement
    // restarts the count, so short excursions never reach data_out.
    // ------------------------------------------------------------------
    localparam int CW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] flt_q;
    logic [CW-1:0]    cnt     [WIDTH];
    logic [CW-1:0]    cnt_nxt [WIDTH];

    assign sync_q = sync[STAGES-1];

    always_comb begin
        data_out_nxt = flt_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = cnt[i];
            if (sync_q[i] == flt_q[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == CW'(FILT_CYCLES - 1)) begin
                data_out_nxt[i] = ~flt_q[i];
                cnt_nxt[i]      = '0;
            end else begin
                cnt_nxt[i] = cnt[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_dst) begin
        if (!rst_n) begin
            flt_q <= RESET_VAL;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            flt_q <= data_out_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    assign data_out = flt_q;
`else
    // Without the filter the last chain stage is the output register, so
    // the data_in -> data_out latency is exactly STAGES edges.
    assign data_out_nxt = sync[STAGES-2];
    assign data_out     = sync[STAGES-1];
`endif

    // ------------------------------------------------------------------
    // Warm-up counter: counts edges after reset release and saturates by
    // freezing once sync_ready is set.
    // ------------------------------------------------------------------
    logic [RW-1:0] warm;

    always_ff @(posedge clk_dst) begin
        if (!rst_n) begin
            warm       <= '0;
            sync_ready <= 1'b0;
        end else if (!sync_ready) begin
            warm <= warm + 1'b1;
            if (warm == RW'(READY_CYC - 1)) begin
                sync_ready <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Edge detection. While warming up, data_out_d is loaded with the value
    // data_out is about to take, so the flush from RESET_VAL (which lands on
    // the same edge that raises sync_ready) never shows up as a pulse.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] data_out_d;

    always_ff @(posedge clk_dst) begin
        if (!rst_n) begin
            data_out_d <= RESET_VAL;
        end else if (sync_ready) begin
            data_out_d <= data_out;
        end else begin
            data_out_d <= data_out_nxt;
        end
    end

    assign rise_pulse =  data_out & ~data_out_d & {WIDTH{sync_ready}};
    assign fall_pulse = ~data_out &  data_out_d & {WIDTH{sync_ready}};

endmodule

// File: tb/tb_cdc_sync_bank.sv
// Purpose : directed self-checking bench for cdc_sync_bank (WIDTH=8, STAGES=3, RESET_VAL=8'hA5).
// Latency : expectations derived from LAT = STAGES (+FILT_CYCLES when the filter is compiled in).
// Backpressure: n/a.

module tb_cdc_sync_bank;

    localparam int         W    = 8;
    localparam int         ST   = 3;
    localparam logic [7:0] RV   = 8'hA5;
    localparam int         FILT = 4;
`ifdef CDC_SYNC_BANK_FILTER_EN
    localparam int         F    = FILT;
`else
    localparam int         F    = 0;
`endif
    localparam int         LAT  = ST + F;

    logic         clk_dst = 1'b0;
    logic         rst_n;
    logic [W-1:0] data_in;
    logic [W-1:0] data_out;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;
    logic         sync_ready;

    int total = 0;
    int bad   = 0;

    cdc_sync_bank #(
        .WIDTH      (W),
        .STAGES     (ST),
        .RESET_VAL  (RV),
        .FILT_CYCLES(FILT)
    ) dut (
        .clk_dst   (clk_dst),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .data_out  (data_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .sync_ready(sync_ready)
    );

    always #5 clk_dst = ~clk_dst;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs and samples both happen 1 time unit after it.
    task automatic step();
        @(posedge clk_dst);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        data_in = 8'h00;

        // Reset held for two edges.
        step();
        step();
        chk("rst_dout",  data_out,   RV);
        chk("rst_rise",  rise_pulse, 8'h00);
        chk("rst_fall",  fall_pulse, 8'h00);
        chk("rst_ready", {7'b0, sync_ready}, 8'h00);

        // Flush: data_out goes A5 -> 00 on the edge that raises sync_ready, no pulses.
        rst_n = 1'b1;
        for (int n = 1; n <= LAT + 1; n++) begin
            step();
            if (n < LAT) begin
                chk("flush_dout_hold", data_out, RV);
                chk("flush_ready_lo", {7'b0, sync_ready}, 8'h00);
            end else begin
                chk("flush_dout_new", data_out, 8'h00);
                chk("flush_ready_hi", {7'b0, sync_ready}, 8'h01);
            end
            chk("flush_fall", fall_pulse, 8'h00);
            chk("flush_rise", rise_pulse, 8'h00);
        end

        // Single-channel latency: bit 0 rises after exactly LAT edges.
        data_in = 8'h01;
        for (int n = 1; n <= LAT + 1; n++) begin
            step();
            if (n < LAT) begin
                chk("lat_dout_early", data_out, 8'h00);
                chk("lat_rise_early", rise_pulse, 8'h00);
            end else if (n == LAT) begin
                chk("lat_dout", data_out, 8'h01);
                chk("lat_rise", rise_pulse, 8'h01);
            end else begin
                chk("lat_dout_after", data_out, 8'h01);
                chk("lat_rise_after", rise_pulse, 8'h00);
            end
        end

        // Bit 0 back to 0: single fall pulse.
        data_in = 8'h00;
        for (int n = 1; n <= LAT + 1; n++) begin
            step();
            if (n == LAT) chk("fall0", fall_pulse, 8'h01);
            if (n == LAT + 1) chk("fall0_after", fall_pulse, 8'h00);
        end

        // All channels at once: 00 -> FF.
        data_in = 8'hFF;
        for (int n = 1; n <= LAT + 1; n++) begin
            step();
            if (n == LAT - 1) chk("all_rise_early", rise_pulse, 8'h00);
            if (n == LAT) begin
                chk("all_rise", rise_pulse, 8'hFF);
                chk("all_dout", data_out, 8'hFF);
            end
            if (n == LAT + 1) chk("all_rise_after", rise_pulse, 8'h00);
        end

        // FF -> 0F: upper nibble falls together.
        data_in = 8'h0F;
        for (int n = 1; n <= LAT + 1; n++) begin
            step();
            if (n == LAT) begin
                chk("nib_fall", fall_pulse, 8'hF0);
                chk("nib_rise", rise_pulse, 8'h00);
                chk("nib_dout", data_out, 8'h0F);
            end
            if (n == LAT + 1) chk("nib_fall_after", fall_pulse, 8'h00);
        end

`ifdef CDC_SYNC_BANK_FILTER_EN
        // Glitch on bit 5 shorter than the filter window is fully suppressed.
        data_in = 8'h2F;
        for (int n = 1; n < FILT; n++) step();
        data_in = 8'h0F;
        for (int n = 1; n <= LAT + FILT; n++) begin
            step();
            chk("glitch_dout", data_out, 8'h0F);
            chk("glitch_rise", rise_pulse, 8'h00);
            chk("glitch_fall", fall_pulse, 8'h00);
        end
`else
        // One-cycle glitch on bit 5 passes through as a one-cycle data_out change.
        data_in = 8'h2F;
        step();
        data_in = 8'h0F;
        for (int n = 2; n <= LAT + 1; n++) begin
            step();
            if (n == LAT) begin
                chk("glitch_dout_hi", data_out, 8'h2F);
                chk("glitch_rise", rise_pulse, 8'h20);
            end
            if (n == LAT + 1) begin
                chk("glitch_dout_lo", data_out, 8'h0F);
                chk("glitch_fall", fall_pulse, 8'h20);
                chk("glitch_rise_off", rise_pulse, 8'h00);
            end
        end
        step();
        chk("glitch_fall_off", fall_pulse, 8'h00);
`endif

        // Reset while bit 1 is in flight (filter count at 2 when compiled in).
        data_in = 8'h0D;
        for (int n = 1; n <= ((F == 0) ? ST - 1 : ST + 2); n++) step();
        chk("mid_dout_pending", data_out, 8'h0F);
        rst_n = 1'b0;
        step();
        chk("mid_rst_dout",  data_out,   RV);
        chk("mid_rst_rise",  rise_pulse, 8'h00);
        chk("mid_rst_fall",  fall_pulse, 8'h00);
        chk("mid_rst_ready", {7'b0, sync_ready}, 8'h00);
        rst_n = 1'b1;
        for (int n = 1; n <= LAT + 1; n++) begin
            step();
            if (n < LAT) begin
                chk("mid_dout_hold", data_out, RV);
            end else begin
                chk("mid_dout_new", data_out, 8'h0D);
                chk("mid_ready", {7'b0, sync_ready}, 8'h01);
            end
            chk("mid_rise", rise_pulse, 8'h00);
            chk("mid_fall", fall_pulse, 8'h00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
